// File: rtl/hall_sequence_generator_pkg.sv
// Shared BLDC types: Hall codes, rotation direction and the sector helpers that the
// Hall sequence generator and the Hall decoding encoder both use.
package hall_sequence_generator_pkg;

    // Hall code bit order is {A, B, C}
    typedef enum logic [2:0] {
        HALL_INVALID = 3'b000,
        HALL_C       = 3'b001,
        HALL_B       = 3'b010,
        HALL_BC      = 3'b011,
        HALL_A       = 3'b100,
        HALL_AC      = 3'b101,
        HALL_AB      = 3'b110
    } hall_states_t;

    typedef enum logic [1:0] {
        DIR_NONE = 2'b00,
        DIR_CW   = 2'b01,
        DIR_CCW  = 2'b10
    } rotation_direction_t;

    typedef enum logic {
        StIdle,
        StRun
    } gen_state_t;

    function automatic hall_states_t sector_to_hall(input logic [2:0] sec);
        hall_states_t hall;
        case (sec)
            3'd0:    hall = HALL_AC;
            3'd1:    hall = HALL_A;
            3'd2:    hall = HALL_AB;
            3'd3:    hall = HALL_B;
            3'd4:    hall = HALL_BC;
            3'd5:    hall = HALL_C;
            default: hall = HALL_INVALID;
        endcase
        return hall;
    endfunction

    function automatic logic [2:0] sector_step(input logic [2:0] sec,
                                               input rotation_direction_t dir);
        logic [2:0] next;
        case (dir)
            DIR_CW:  next = (sec >= 3'd5) ? 3'd0 : sec + 3'd1;
            DIR_CCW: next = (sec == 3'd0 || sec > 3'd5) ? 3'd5 : sec - 3'd1;
            default: next = sec;
        endcase
        return next;
    endfunction

endpackage

// File: rtl/hall_sequence_generator.sv
// Six-step Hall sequence emulator with a valid/ready command port and a one-entry shadow
// applied only at step boundaries. Optional HALL_SEQ_FAULT_INJECT_EN adds fault_inject.
module hall_sequence_generator
    import hall_sequence_generator_pkg::*;
#(
    parameter int unsigned clk_freq_hz   = 27_000_000,
    parameter int unsigned counter_width = 32,
    parameter int unsigned min_period    = 2,
    parameter int unsigned init_sector   = 0
) (
    input  logic                       clk,
    input  logic                       reset_n,
`ifdef HALL_SEQ_FAULT_INJECT_EN
    input  logic                       fault_inject,
`endif
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  rotation_direction_t        cmd_direction,
    input  logic [counter_width-1:0]   cmd_period,
    output hall_states_t               hall_values,
    output logic [2:0]                 sector,
    output logic                       step_pulse,
    output logic [counter_width-1:0]   position,
    output logic                       running
);

    localparam logic [counter_width-1:0] One        = counter_width'(1);
    localparam logic [counter_width-1:0] MinPeriod  = counter_width'(min_period);
    localparam logic [2:0]               InitSector = 3'(init_sector);

    if (init_sector > 5 || min_period < 1 || clk_freq_hz == 0) begin : gen_param_check
        $error("hall_sequence_generator: invalid parameter set");
    end

    gen_state_t                 state_q, state_d;
    rotation_direction_t        dir_q, dir_d, shadow_dir_q, shadow_dir_d, step_dir;
    logic [counter_width-1:0]   period_q, period_d, shadow_period_q, shadow_period_d;
    logic [counter_width-1:0]   timer_q, timer_d, position_q, position_d, eff_period;
    logic                       shadow_valid_q, shadow_valid_d;
    logic [2:0]                 sector_q, sector_d;
    hall_states_t               hall_q, hall_d;
    logic                       step_q, step_d;
    logic                       cmd_accept, freeze;

`ifdef HALL_SEQ_FAULT_INJECT_EN
    assign freeze = fault_inject;
`else
    assign freeze = 1'b0;
`endif

    assign cmd_ready  = !shadow_valid_q;
    assign cmd_accept = cmd_valid && cmd_ready;
    assign eff_period = (cmd_period < MinPeriod) ? MinPeriod : cmd_period;

    always_comb begin
        state_d         = state_q;
        dir_d           = dir_q;
        period_d        = period_q;
        timer_d         = timer_q;
        shadow_valid_d  = shadow_valid_q;
        shadow_dir_d    = shadow_dir_q;
        shadow_period_d = shadow_period_q;
        sector_d        = sector_q;
        position_d      = position_q;
        step_d          = 1'b0;
        step_dir        = dir_q;

        case (state_q)
            StIdle: begin
                // Start commands bypass the shadow; DIR_NONE while idle is dropped.
                if (cmd_accept && (cmd_direction == DIR_CW || cmd_direction == DIR_CCW)) begin
                    dir_d    = cmd_direction;
                    period_d = eff_period;
                    timer_d  = '0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                if (cmd_accept) begin
                    shadow_valid_d  = 1'b1;
                    shadow_dir_d    = cmd_direction;
                    shadow_period_d = eff_period;
                end
                if (!freeze) begin
                    if (timer_q == period_q - One) begin
                        timer_d = '0;
                        // The shadow is promoted before the step so a reversal or stop
                        // takes effect on this very boundary.
                        if (shadow_valid_q) begin
                            step_dir       = shadow_dir_q;
                            dir_d          = shadow_dir_q;
                            period_d       = shadow_period_q;
                            shadow_valid_d = 1'b0;
                        end
                        if (step_dir == DIR_CW || step_dir == DIR_CCW) begin
                            sector_d   = sector_step(sector_q, step_dir);
                            position_d = (step_dir == DIR_CW) ? position_q + One
                                                              : position_q - One;
                            step_d     = 1'b1;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        timer_d = timer_q + One;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

`ifdef HALL_SEQ_FAULT_INJECT_EN
        hall_d = freeze ? HALL_INVALID : sector_to_hall(sector_d);
`else
        hall_d = sector_to_hall(sector_d);
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= StIdle;
            dir_q           <= DIR_NONE;
            period_q        <= MinPeriod;
            timer_q         <= '0;
            shadow_valid_q  <= 1'b0;
            shadow_dir_q    <= DIR_NONE;
            shadow_period_q <= MinPeriod;
            sector_q        <= InitSector;
            position_q      <= '0;
            hall_q          <= sector_to_hall(InitSector);
            step_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            dir_q           <= dir_d;
            period_q        <= period_d;
            timer_q         <= timer_d;
            shadow_valid_q  <= shadow_valid_d;
            shadow_dir_q    <= shadow_dir_d;
            shadow_period_q <= shadow_period_d;
            sector_q        <= sector_d;
            position_q      <= position_d;
            hall_q          <= hall_d;
            step_q          <= step_d;
        end
    end

    assign hall_values = hall_q;
    assign sector      = sector_q;
    assign step_pulse  = step_q;
    assign position    = position_q;
    assign running     = (state_q == StRun);

endmodule

// File: tb/tb_hall_sequence_generator.sv
// Directed bench for hall_sequence_generator: expected steps are queued when commands are
// driven and checked as step_pulse strobes arrive.
module tb_hall_sequence_generator;
    import hall_sequence_generator_pkg::*;

    typedef struct {
        hall_states_t hall;
        logic [2:0]   sec;
        logic [31:0]  pos;
        int           delay;
    } exp_t;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                fault_inject = 1'b0;
    logic                cmd_valid = 1'b0;
    logic                cmd_ready;
    rotation_direction_t cmd_direction = DIR_NONE;
    logic [31:0]         cmd_period = 32'd0;
    hall_states_t        hall_values;
    logic [2:0]          sector;
    logic                step_pulse;
    logic [31:0]         position;
    logic                running;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    hall_sequence_generator #(
        .clk_freq_hz  (27_000_000),
        .counter_width(32),
        .min_period   (2),
        .init_sector  (0)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
`ifdef HALL_SEQ_FAULT_INJECT_EN
        .fault_inject (fault_inject),
`endif
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_direction(cmd_direction),
        .cmd_period   (cmd_period),
        .hall_values  (hall_values),
        .sector       (sector),
        .step_pulse   (step_pulse),
        .position     (position),
        .running      (running)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push(input hall_states_t h, input logic [2:0] s, input logic [31:0] p,
                        input int d);
        exp_t e;
        e.hall = h; e.sec = s; e.pos = p; e.delay = d;
        sb.push_back(e);
    endtask

    task automatic send_cmd(input string tag, input rotation_direction_t dir,
                            input logic [31:0] per);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_direction = dir; cmd_period = per;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, {31'b0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_step(input string tag);
        exp_t e;
        int   n = 0;
        logic got = 1'b0;
        e = sb.pop_front();
        while (!got && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            got = step_pulse;
        end
        check({tag, "_pulse"}, {31'b0, got}, 32'd1);
        check({tag, "_delay"}, n, e.delay);
        check({tag, "_hall"}, {29'b0, hall_values}, {29'b0, e.hall});
        check({tag, "_sector"}, {29'b0, sector}, {29'b0, e.sec});
        check({tag, "_pos"}, position, e.pos);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        int pulses = 0;
        while (running && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (step_pulse) pulses++;
        end
        check({tag, "_running"}, {31'b0, running}, 32'd0);
        check({tag, "_pulses"}, pulses, 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_hall"}, {29'b0, hall_values}, {29'b0, HALL_AC});
        check({tag, "_sector"}, {29'b0, sector}, 32'd0);
        check({tag, "_pos"}, position, 32'd0);
        check({tag, "_running"}, {31'b0, running}, 32'd0);
        check({tag, "_ready"}, {31'b0, cmd_ready}, 32'd1);
        check({tag, "_pulse"}, {31'b0, step_pulse}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check_reset_state("rst");
        reset_n = 1'b1;

        // CW, P=4: one full electrical revolution
        send_cmd("cw4", DIR_CW, 32'd4);
        push(HALL_A, 3'd1, 32'd1, 4);
        push(HALL_AB, 3'd2, 32'd2, 4);
        push(HALL_B, 3'd3, 32'd3, 4);
        push(HALL_BC, 3'd4, 32'd4, 4);
        push(HALL_C, 3'd5, 32'd5, 4);
        push(HALL_AC, 3'd0, 32'd6, 4);
        for (int i = 0; i < 6; i++) wait_step($sformatf("cw4_s%0d", i));
        send_cmd("stop1", DIR_NONE, 32'd4);
        wait_idle("stop1");
        check("stop1_hall", {29'b0, hall_values}, {29'b0, HALL_AC});
        check("stop1_pos", position, 32'd6);

        // CCW, P=3 from sector 0 wraps position to all-ones
        do_reset();
        send_cmd("ccw3", DIR_CCW, 32'd3);
        push(HALL_C, 3'd5, 32'hFFFF_FFFF, 3);
        wait_step("ccw3");

        // Asynchronous reset in the middle of a step
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check_reset_state("midrst");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Shadow and backpressure: CW P=10, then CCW P=5 shadowed
        send_cmd("cw10", DIR_CW, 32'd10);
        push(HALL_A, 3'd1, 32'd1, 10);
        wait_step("cw10");
        send_cmd("ccw5", DIR_CCW, 32'd5);
        check("shadow_full_ready", {31'b0, cmd_ready}, 32'd0);
        cmd_valid = 1'b1; cmd_direction = DIR_CW; cmd_period = 32'd7;
        push(HALL_AC, 3'd0, 32'd0, 9);
        wait_step("rev");
        check("stall_released_ready", {31'b0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1;
        check("stall_taken_ready", {31'b0, cmd_ready}, 32'd0);
        cmd_valid = 1'b0;
        push(HALL_A, 3'd1, 32'd1, 4);
        push(HALL_AB, 3'd2, 32'd2, 7);
        wait_step("ccw5_to_cw");
        wait_step("cw7");

        // Period 0 clamps to 2, then a shadowed stop
        send_cmd("clamp", DIR_CW, 32'd0);
        push(HALL_B, 3'd3, 32'd3, 6);
        push(HALL_BC, 3'd4, 32'd4, 2);
        push(HALL_C, 3'd5, 32'd5, 2);
        for (int i = 0; i < 3; i++) wait_step($sformatf("clamp_s%0d", i));
        send_cmd("stop2", DIR_NONE, 32'd9);
        wait_idle("stop2");
        check("stop2_hall", {29'b0, hall_values}, {29'b0, HALL_C});
        check("stop2_sector", {29'b0, sector}, 32'd5);

`ifdef HALL_SEQ_FAULT_INJECT_EN
        // Fault forcing freezes the timer for six cycles mid-step
        do_reset();
        send_cmd("flt", DIR_CW, 32'd4);
        push(HALL_A, 3'd1, 32'd1, 4);
        wait_step("flt_s0");
        @(posedge clk);
        #1;
        fault_inject = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("flt_hall%0d", i), {29'b0, hall_values}, 32'd0);
            check($sformatf("flt_pulse%0d", i), {31'b0, step_pulse}, 32'd0);
        end
        fault_inject = 1'b0;
        push(HALL_AB, 3'd2, 32'd2, 3);
        wait_step("flt_s1");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
